// File: rtl/core_pkg.sv
// Shared core types and constants, including the load/store unit state encoding
// and the RV32I funct3 width/sign codes used by the data-memory path.
package core_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int DATA_MEM_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_RESP = 2'd1,
        RMW_WRITE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we)
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (f3 == F3_H || f3 == F3_HU)
            bad = off[0];
        else if (f3 == F3_W)
            bad = (off != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit: extracts and extends
// load data from a memory word and merges sub-word store data into a word.
module lsu_align
    import core_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic [DW-1:0] word_i,
    input  logic [1:0]    offset_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] load_data_o,
    output logic [DW-1:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        load_data_o = word_i;
        unique case (funct3_i)
            F3_B:    load_data_o = {{(DW-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {{(DW-8){1'b0}}, byte_sel};
            F3_H:    load_data_o = {{(DW-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {{(DW-16){1'b0}}, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        store_word_o = word_i;
        if (funct3_i == F3_B)
            store_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
        else if (funct3_i == F3_H)
            store_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        else
            store_word_o = wdata_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the single-port, word-wide data memory. Sub-word
// stores run as read-modify-write because the memory only takes full words.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | accept a request; SW completes here in one cycle
//   LOAD_RESP | present the extended load result from the captured word
//   RMW_WRITE | write the captured word with the new byte/halfword merged
module load_store_unit
    import core_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          stall_o,
    output logic          load_valid_o,
    output logic [DW-1:0] load_data_o,
    output logic          misaligned_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wr_data_o,
    output logic          MemWrite_o,
    output logic          MemRead_o,
    input  logic [DW-1:0] mem_rd_data_i
);

    lsu_state_e    state_q, state_d;
    logic [DW-1:0] word_q;
    logic [DW-1:0] addr_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] ld_last_q;
    logic          cap_en;

    logic [DW-1:0] ld_ext;
    logic [DW-1:0] st_merged;
    logic          req_legal;
    logic          req_misaligned;

    lsu_align #(.DW(DW)) u_align (
        .word_i       (word_q),
        .offset_i     (off_q),
        .funct3_i     (f3_q),
        .wdata_i      (wdata_q),
        .load_data_o  (ld_ext),
        .store_word_o (st_merged)
    );

    assign req_legal      = f3_legal(req_we_i, req_funct3_i);
    assign req_misaligned = f3_misaligned(req_funct3_i, req_addr_i[1:0]);

    always_comb begin
        state_d       = state_q;
        cap_en        = 1'b0;
        stall_o       = 1'b0;
        load_valid_o  = 1'b0;
        misaligned_o  = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        MemWrite_o    = 1'b0;
        MemRead_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_legal) begin
                    if (req_misaligned) begin
                        misaligned_o = 1'b1;
                    end else if (req_we_i && req_funct3_i == F3_W) begin
                        MemWrite_o    = 1'b1;
                        mem_addr_o    = req_addr_i;
                        mem_wr_data_o = req_wdata_i;
                    end else begin
                        MemRead_o  = 1'b1;
                        mem_addr_o = req_addr_i;
                        stall_o    = 1'b1;
                        cap_en     = 1'b1;
                        state_d    = req_we_i ? RMW_WRITE : LOAD_RESP;
                    end
                end
            end
            LOAD_RESP: begin
                load_valid_o = 1'b1;
                state_d      = IDLE;
            end
            RMW_WRITE: begin
                MemWrite_o    = 1'b1;
                mem_addr_o    = addr_q;
                mem_wr_data_o = st_merged;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must suppress strobes in the same cycle, or a pending RMW
        // write would land at the very edge that resets the FSM.
        if (!rst_n) begin
            cap_en        = 1'b0;
            stall_o       = 1'b0;
            load_valid_o  = 1'b0;
            misaligned_o  = 1'b0;
            mem_addr_o    = '0;
            mem_wr_data_o = '0;
            MemWrite_o    = 1'b0;
            MemRead_o     = 1'b0;
        end
    end

    assign load_data_o = (state_q == LOAD_RESP) ? ld_ext : ld_last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            addr_q    <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            wdata_q   <= '0;
            ld_last_q <= '0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                word_q  <= mem_rd_data_i;
                addr_q  <= req_addr_i;
                off_q   <= req_addr_i[1:0];
                f3_q    <= req_funct3_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == LOAD_RESP)
                ld_last_q <= ld_ext;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator for the word-wide, single-port data memory. It accepts one load/store request from the pipeline, drives the memory address, write data and MemRead/MemWrite strobes, and returns sign- or zero-extended load data. Sub-word stores run as a two-cycle read-modify-write, because the memory only accepts full-word writes. It raises a stall to the pipeline while a multi-cycle access is in flight.

Parameters:
DATA_WIDTH, 32 (from core_pkg), data and address width.
DATA_MEM_ADDR_WIDTH, from core_pkg, word-index width. The memory itself decodes address bits [DATA_MEM_ADDR_WIDTH+1:2].

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
req_valid_i  input  1  MEM-stage instruction is a load or store.
req_we_i  input  1  1 = store, 0 = load.
req_funct3_i  input  3  RV32I width/sign code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
req_addr_i  input  DATA_WIDTH  byte address (ALU result).
req_wdata_i  input  DATA_WIDTH  store data (rs2), LSB-aligned.
stall_o  output  1  hold the MEM stage and everything upstream.
load_valid_o  output  1  load_data_o is valid this cycle.
load_data_o  output  DATA_WIDTH  extended load result.
misaligned_o  output  1  the current request is misaligned. No memory access is made.
mem_addr_o  output  DATA_WIDTH  address to the data memory.
mem_wr_data_o  output  DATA_WIDTH  full-word write data.
MemWrite_o  output  1  write strobe; the memory writes at the next rising edge.
MemRead_o  output  1  read enable. The memory returns data combinationally.
mem_rd_data_i  input  DATA_WIDTH  read data; 0 when MemRead_o is 0.

Behaviour:
- FSM states: IDLE, LOAD_RESP, RMW_WRITE.
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - capture registers (word, address, offset, funct3, store data) clear to 0.
  - all outputs are 0 while in IDLE with req_valid_i=0.
- Reset mid-operation abandons the access. A pending RMW write is never issued.
- Alignment:
  - halfword accesses are misaligned if addr[0]=1.
  - word accesses are misaligned if addr[1:0]!=0.
  - byte accesses are never misaligned.
- IDLE, request with a misaligned address or illegal funct3 (011, 110, 111):
  - misaligned_o=1 for misaligned only; it is combinational and only asserted in IDLE.
  - MemRead_o=MemWrite_o=0, stall_o=0, stay IDLE.
- IDLE, load (aligned):
  - MemRead_o=1, mem_addr_o=req_addr_i, stall_o=1.
  - capture mem_rd_data_i, addr[1:0] and funct3.
  - next state LOAD_RESP.
- LOAD_RESP:
  - load_valid_o=1, stall_o=0, no memory strobes.
  - load_data_o is extracted from the captured word:
    - byte selected by offset, halfword selected by offset[1].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - next state IDLE. Inputs are ignored in this state, since the pipeline still holds the same request.
  - Load latency is 2 cycles, with 1 stall cycle.
- IDLE, SW (aligned):
  - MemWrite_o=1, mem_addr_o=req_addr_i, mem_wr_data_o=req_wdata_i.
  - stall_o=0, stay IDLE. Single cycle.
- IDLE, SB/SH (aligned):
  - MemRead_o=1, stall_o=1.
  - capture mem_rd_data_i, the address, offset, funct3 and req_wdata_i.
  - next state RMW_WRITE.
- RMW_WRITE:
  - MemWrite_o=1, mem_addr_o=captured address, stall_o=0.
  - mem_wr_data_o=captured word with the addressed byte (SB, req_wdata[7:0]) or halfword (SH, req_wdata[15:0]) replaced; all other bytes are unchanged.
  - next state IDLE.
- load_data_o holds its last value outside LOAD_RESP. Consumers use it only when load_valid_o=1.
- mem_addr_o and mem_wr_data_o are 0 when neither strobe is active.
- MemRead_o and MemWrite_o are never both 1.

Decomposition:
- core_pkg additions:
  - lsu_state_e enum (IDLE, LOAD_RESP, RMW_WRITE).
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_align, purely combinational:
  - load extract/extend from (word, offset, funct3).
  - store merge from (old word, offset, funct3, wdata).
  - unit-testable on its own.
- The FSM and capture registers stay in load_store_unit.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid_i=1 (SB) -> no strobes, stall_o=0, load_valid_o=0; after release the FSM starts in IDLE.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> 1 cycle MemWrite_o; LW asserts stall_o for 1 cycle; next cycle load_valid_o=1, load_data_o=0xDEADBEEF.
- Word 0x8081F2F3 at 0x20: LB 0x21 -> 0xFFFFFFF2; LBU 0x21 -> 0x000000F2; LH 0x22 -> 0xFFFF8081; LHU 0x22 -> 0x00008081.
- Word 0x11223344 at 0x30, SB 0x32 data 0xAB -> cycle 1: MemRead_o=1, stall_o=1; cycle 2: MemWrite_o=1 with 0x11AB3344; a following LW returns 0x11AB3344. SH 0x30 data 0xCAFE -> 0x11ABCAFE.
- LW 0x41, SH 0x43, LH 0x45 -> misaligned_o=1, no strobes, stall_o=0, memory contents unchanged. SB 0x43 is accepted normally.
- rst_n=0 during RMW_WRITE of SB 0x50 -> no MemWrite_o pulse; the word at 0x50 is unchanged; FSM is in IDLE after reset.
